// File: rtl/mul_digit_serial.sv
// mul_digit_serial: digit-serial unsigned multiplier (X*Y), Y consumed MSB digit first, valid/ready in and out
// clk, rst (sync, active-low); in_valid/in_ready with X, Y; out_valid/out_ready with product_result; busy high in RUN
module mul_digit_serial #(
  parameter int WIDTH = 255,
  parameter int DIGIT = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product_result,
  output logic                 busy
);
  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PW = NDIG * DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] x_reg;
  logic [PW-1:0] y_reg;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH+DIGIT-1:0] pp;
  logic [DIGIT-1:0] dig;
  logic [CW-1:0] cnt;
  logic accept;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  // y_reg shifts left each RUN cycle, so the current digit is always at the top
  assign dig = y_reg[PW-1 -: DIGIT];
  assign pp = {{DIGIT{1'b0}}, x_reg} * {{WIDTH{1'b0}}, dig};
  assign acc_nxt = (acc << DIGIT) + (2*WIDTH)'(pp);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      x_reg <= '0;
      y_reg <= '0;
      product_result <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else if (accept) begin
      x_reg <= X;
      y_reg <= PW'(Y);
      acc <= '0;
      cnt <= CW'(NDIG - 1);
      state <= RUN;
      busy <= 1'b1;
      out_valid <= 1'b0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      y_reg <= y_reg << DIGIT;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        product_result <= acc_nxt;
        out_valid <= 1'b1;
        busy <= 1'b0;
        state <= DONE;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mul_digit_serial.sv
// tb_mul_digit_serial: directed + random checks of mul_digit_serial against a cycle-level behavioural model
module tb_mul_digit_serial;
  localparam int NDIG = 15;
  logic clk, rst, iv, ir, ov, ordy, busy;
  logic [254:0] x_in, y_in;
  logic [509:0] prod;
  logic s_iv, s_ir, s_ov, s_busy, t_iv, t_ir, t_ov, t_busy;
  logic one = 1'b1;
  logic [7:0] s_x, s_y, t_x, t_y;
  logic [15:0] s_p, t_p;
  int checks = 0, errors = 0;
  bit chk_on = 0;
  logic m_ov, m_busy, m_ir;
  logic [509:0] m_prod, m_pend;
  int m_left;

  mul_digit_serial dut (.clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .X(x_in), .Y(y_in),
    .out_valid(ov), .out_ready(ordy), .product_result(prod), .busy(busy));
  mul_digit_serial #(.WIDTH(8), .DIGIT(3)) dut_s (.clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir),
    .X(s_x), .Y(s_y), .out_valid(s_ov), .out_ready(one), .product_result(s_p), .busy(s_busy));
  mul_digit_serial #(.WIDTH(8), .DIGIT(8)) dut_t (.clk(clk), .rst(rst), .in_valid(t_iv), .in_ready(t_ir),
    .X(t_x), .Y(t_y), .out_valid(t_ov), .out_ready(one), .product_result(t_p), .busy(t_busy));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [509:0] a, input logic [509:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // model: an accepted pair yields its exact product NDIG edges later, held until out_ready
  assign m_ir = !m_busy && (!m_ov || ordy);
  always @(posedge clk) begin
    if (!rst) begin
      m_ov <= 0; m_busy <= 0; m_prod <= '0; m_left <= 0;
    end else if (iv && m_ir) begin
      m_pend <= 510'(x_in) * 510'(y_in); m_left <= NDIG; m_busy <= 1; m_ov <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_prod <= m_pend; m_ov <= 1; m_busy <= 0;
      end
    end else if (m_ov && ordy) m_ov <= 0;
  end

  always @(negedge clk) if (chk_on) begin
    chk("model out_valid", 510'(ov), 510'(m_ov));
    chk("model busy", 510'(busy), 510'(m_busy));
    chk("model in_ready", 510'(ir), 510'(m_ir));
    chk("model product", prod, m_prod);
  end

  task automatic wait_done(output int lat, output int bc);
    lat = 0; bc = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (busy) bc++;
      if (ov) break;
      @(posedge clk);
      lat++;
    end
    chk("done timeout", 510'(lat < 100), 510'(1));
  endtask

  task automatic run_op(input logic [254:0] x, input logic [254:0] y, input logic r, output int lat, output int bc);
    @(posedge clk); #2 iv = 1; x_in = x; y_in = y; ordy = r;
    @(posedge clk); #2 iv = 0;
    wait_done(lat, bc);
  endtask

  task automatic op_s(input logic [7:0] x, input logic [7:0] y);
    int lat = 0;
    @(posedge clk); #2 s_iv = 1; s_x = x; s_y = y;
    @(posedge clk); #2 s_iv = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (s_ov) break;
      @(posedge clk);
      lat++;
    end
    chk("w8d3 latency", 510'(lat), 510'(3));
    chk("w8d3 product", 510'(s_p), 510'(16'(x) * 16'(y)));
  endtask

  task automatic op_t(input logic [7:0] x, input logic [7:0] y);
    int lat = 0;
    @(posedge clk); #2 t_iv = 1; t_x = x; t_y = y;
    @(posedge clk); #2 t_iv = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (t_ov) break;
      @(posedge clk);
      lat++;
    end
    chk("w8d8 latency", 510'(lat), 510'(1));
    chk("w8d8 product", 510'(t_p), 510'(16'(x) * 16'(y)));
  endtask

  initial begin
    int lat, bc;
    logic [254:0] mx, rx, ry;
    logic [509:0] e;
    rst = 0; iv = 0; ordy = 1; x_in = '0; y_in = '0;
    s_iv = 0; s_x = 0; s_y = 0; t_iv = 0; t_x = 0; t_y = 0;
    mx = '1;
    repeat (3) @(posedge clk);
    #2 chk_on = 1;
    @(negedge clk);
    chk("reset out_valid", 510'(ov), 510'(0));
    chk("reset product", prod, 510'(0));
    chk("reset busy", 510'(busy), 510'(0));
    chk("reset in_ready", 510'(ir), 510'(1));
    @(posedge clk); #2 rst = 1;
    run_op(255'(3), 255'(5), 1, lat, bc);
    chk("3x5 latency", 510'(lat), 510'(15));
    chk("3x5 busy cycles", 510'(bc), 510'(15));
    chk("3x5 product", prod, 510'(15));
    run_op(mx, mx, 1, lat, bc);
    e = 510'((511'(1) << 510) - (511'(1) << 256) + 511'(1));
    chk("max x max", prod, e);
    run_op('0, mx, 1, lat, bc);
    chk("0 x max latency", 510'(lat), 510'(15));
    chk("0 x max product", prod, 510'(0));
    run_op(255'(1234), 255'(5678), 0, lat, bc);
    chk("stall product", prod, 510'(7006652));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2 iv = 1; x_in = 255'(i + 100); y_in = 255'(i * 7 + 1);
      @(negedge clk);
      chk("stall hold", prod, 510'(7006652));
      chk("stall in_ready", 510'(ir), 510'(0));
      chk("stall out_valid", 510'(ov), 510'(1));
    end
    @(posedge clk); #2 iv = 0; ordy = 1;
    run_op(255'(7), 255'(9), 0, lat, bc);
    chk("A product", prod, 510'(63));
    @(posedge clk); #2 ordy = 1; iv = 1; x_in = 255'(1) << 200; y_in = 255'(1) << 54;
    @(negedge clk);
    chk("b2b in_ready", 510'(ir), 510'(1));
    chk("b2b A still valid", 510'(ov), 510'(1));
    @(posedge clk); #2 iv = 0;
    wait_done(lat, bc);
    chk("B latency", 510'(lat), 510'(15));
    chk("B product", prod, 510'(1) << 254);
    @(posedge clk); #2 iv = 1; x_in = 255'(123); y_in = 255'(456);
    @(posedge clk); #2 iv = 0;
    repeat (9) @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #2 rst = 1;
    @(negedge clk);
    chk("abort out_valid", 510'(ov), 510'(0));
    chk("abort product", prod, 510'(0));
    chk("abort busy", 510'(busy), 510'(0));
    chk("abort in_ready", 510'(ir), 510'(1));
    run_op(255'(11), 255'(13), 1, lat, bc);
    chk("11x13", prod, 510'(143));
    for (int i = 0; i < 4; i++) begin
      rx = 255'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      ry = 255'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      run_op(rx, ry, 1, lat, bc);
      chk("random latency", 510'(lat), 510'(15));
    end
    op_s(8'd255, 8'd255);
    chk("w8d3 255x255", 510'(s_p), 510'(65025));
    op_s(8'd0, 8'd0);
    op_s(8'd1, 8'd200);
    op_t(8'd255, 8'd255);
    chk("w8d8 255x255", 510'(t_p), 510'(65025));
    for (int i = 0; i < 8; i++) begin
      op_s(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      op_t(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
